// File: rtl/pll_supervisor.sv
// Lock supervisor and reset sequencer for an iCE40 PLL: drives RESETB, watches LOCK,
// relocks on timeout and releases downstream resets one after another once lock is stable.
module pll_supervisor #(
  parameter int NUM_OUT          = 3,
  parameter int PLL_RST_CYCLES   = 4,
  parameter int RELOCK_TIMEOUT   = 65536,
  parameter int LOCK_HOLD_CYCLES = 1024,
  parameter int STAGGER_CYCLES   = 16,
  parameter int COUNT_W          = 8
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               locked_in,
  input  logic               force_relock,
  output logic               pll_resetb,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               ready,
  output logic [COUNT_W-1:0] loss_count,
  output logic [COUNT_W-1:0] timeout_count
);
  localparam int RST_W  = $clog2(PLL_RST_CYCLES + 1);
  localparam int WAIT_W = $clog2(RELOCK_TIMEOUT);
  localparam int HOLD_W = $clog2(LOCK_HOLD_CYCLES + 1);
  localparam int STAG_W = $clog2(STAGGER_CYCLES + 1);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync_q;
  logic               lock_s;
  logic [RST_W-1:0]   rst_tmr_q, rst_tmr_d;
  logic [WAIT_W-1:0]  wait_tmr_q, wait_tmr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [STAG_W-1:0]  stag_q, stag_d;
  logic               pll_resetb_q, pll_resetb_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d, rst_shift;
  logic               ready_q, ready_d;
  logic [COUNT_W-1:0] loss_q, loss_d, tmo_q, tmo_d;
  logic               relock, count_loss, count_timeout;

  assign lock_s = sync_q[1];
  // Releasing the next reset is a left shift: bits leave the vector from index 0 upward.
  assign rst_shift = rst_out_q << 1;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q      <= S_PLL_RESET;
      sync_q       <= 2'b00;
      rst_tmr_q    <= '0;
      wait_tmr_q   <= '0;
      hold_q       <= '0;
      stag_q       <= '0;
      pll_resetb_q <= 1'b0;
      rst_out_q    <= '1;
      ready_q      <= 1'b0;
      loss_q       <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[0], locked_in};
      rst_tmr_q    <= rst_tmr_d;
      wait_tmr_q   <= wait_tmr_d;
      hold_q       <= hold_d;
      stag_q       <= stag_d;
      pll_resetb_q <= pll_resetb_d;
      rst_out_q    <= rst_out_d;
      ready_q      <= ready_d;
      loss_q       <= loss_d;
      tmo_q        <= tmo_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rst_tmr_d     = rst_tmr_q;
    wait_tmr_d    = wait_tmr_q;
    hold_d        = hold_q;
    stag_d        = stag_q;
    pll_resetb_d  = pll_resetb_q;
    rst_out_d     = rst_out_q;
    ready_d       = ready_q;
    loss_d        = loss_q;
    tmo_d         = tmo_q;
    relock        = 1'b0;
    count_loss    = 1'b0;
    count_timeout = 1'b0;

    case (state_q)
      // force_relock is ignored here so a repeated request cannot stretch RESETB.
      S_PLL_RESET: begin
        if (rst_tmr_q == RST_W'(PLL_RST_CYCLES)) begin
          state_d      = S_WAIT_LOCK;
          pll_resetb_d = 1'b1;
          wait_tmr_d   = '0;
        end else begin
          rst_tmr_d = rst_tmr_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (force_relock) begin
          relock = 1'b1;
        end else if (lock_s) begin
          state_d = S_STABLE;
          hold_d  = '0;
        end else if (wait_tmr_q == WAIT_W'(RELOCK_TIMEOUT - 1)) begin
          relock        = 1'b1;
          count_timeout = 1'b1;
        end else begin
          wait_tmr_d = wait_tmr_q + 1'b1;
        end
      end
      S_STABLE: begin
        if (force_relock) begin
          relock = 1'b1;
        end else if (!lock_s) begin
          state_d    = S_WAIT_LOCK;
          wait_tmr_d = '0;
        end else if (hold_q == HOLD_W'(LOCK_HOLD_CYCLES - 1)) begin
          rst_out_d = rst_shift;
          stag_d    = '0;
          if (rst_shift == '0) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!lock_s) begin
          relock     = 1'b1;
          count_loss = 1'b1;
        end else if (force_relock) begin
          relock = 1'b1;
        end else if (stag_q == STAG_W'(STAGGER_CYCLES - 1)) begin
          rst_out_d = rst_shift;
          stag_d    = '0;
          if (rst_shift == '0) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end
        end else begin
          stag_d = stag_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          relock     = 1'b1;
          count_loss = 1'b1;
        end else if (force_relock) begin
          relock = 1'b1;
        end
      end
      default: relock = 1'b1;
    endcase

    // Entry from a running state counts as the first RESETB-low cycle, hence the load of 1.
    if (relock) begin
      state_d      = S_PLL_RESET;
      pll_resetb_d = 1'b0;
      rst_out_d    = '1;
      ready_d      = 1'b0;
      rst_tmr_d    = RST_W'(1);
    end
    if (count_loss && (loss_q != '1)) loss_d = loss_q + 1'b1;
    if (count_timeout && (tmo_q != '1)) tmo_d = tmo_q + 1'b1;
  end

  assign pll_resetb    = pll_resetb_q;
  assign rst_out       = rst_out_q;
  assign ready         = ready_q;
  assign loss_count    = loss_q;
  assign timeout_count = tmo_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: timeline vectors, directed corner sequences and randomised lock traffic.
module tb_pll_supervisor;
  localparam int N = 3, PRC = 4, TO = 100, HOLD = 8, STAG = 5, CW = 4;
  localparam int P_RST = 0, P_WAIT = 1, P_HOLD = 2, P_REL = 3;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0, reset = 1'b1, locked_in = 1'b0, force_relock = 1'b0;
  logic          pll_resetb, ready;
  logic [N-1:0]  rst_out;
  logic [CW-1:0] loss_count, timeout_count;

  int total = 0, bad = 0, nxt = 0;
  bit quiet = 1'b0;

  always #5 clk = ~clk;

  pll_supervisor #(
    .NUM_OUT(N), .PLL_RST_CYCLES(PRC), .RELOCK_TIMEOUT(TO),
    .LOCK_HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG), .COUNT_W(CW)
  ) dut (
    .clock_in(clk), .reset(reset), .locked_in(locked_in), .force_relock(force_relock),
    .pll_resetb(pll_resetb), .rst_out(rst_out), .ready(ready),
    .loss_count(loss_count), .timeout_count(timeout_count)
  );

  // Reference: a phase plus the number of edges spent in it; release progress is arithmetic on that.
  int   m_ph, m_el, m_lc, m_tc;
  logic m_h0, m_h1;

  task automatic model_step(input logic r, input logic lk, input logic frc);
    logic ls;
    bit   rl;
    if (r) begin
      m_ph = P_RST; m_el = -1; m_h0 = 1'b0; m_h1 = 1'b0; m_lc = 0; m_tc = 0;
      return;
    end
    ls = m_h1; m_h1 = m_h0; m_h0 = lk; rl = 1'b0;
    case (m_ph)
      P_RST: if (m_el == PRC - 1) begin m_ph = P_WAIT; m_el = 0; end else m_el++;
      P_WAIT: begin
        if (frc) rl = 1'b1;
        else if (ls) begin m_ph = P_HOLD; m_el = 0; end
        else if (m_el == TO - 1) begin rl = 1'b1; if (m_tc < SAT) m_tc++; end
        else m_el++;
      end
      P_HOLD: begin
        if (frc) rl = 1'b1;
        else if (!ls) begin m_ph = P_WAIT; m_el = 0; end
        else if (m_el == HOLD - 1) begin m_ph = P_REL; m_el = 0; end
        else m_el++;
      end
      default: begin
        if (!ls) begin rl = 1'b1; if (m_lc < SAT) m_lc++; end
        else if (frc) rl = 1'b1;
        else if (m_el < 1000) m_el++;
      end
    endcase
    if (rl) begin m_ph = P_RST; m_el = 0; end
  endtask

  function automatic logic [31:0] model_vec();
    logic [N-1:0] ro;
    logic         rdy;
    ro = '1; rdy = 1'b0;
    if (m_ph == P_REL) begin
      for (int i = 0; i < N; i++) ro[i] = (m_el < i * STAG);
      rdy = (m_el >= (N - 1) * STAG);
    end
    return 32'({m_ph != P_RST, ro, rdy, CW'(m_lc), CW'(m_tc)});
  endfunction

  function automatic logic [31:0] dut_vec();
    return 32'({pll_resetb, rst_out, ready, loss_count, timeout_count});
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(reset, locked_in, force_relock);
    #1;
    nxt++;
  endtask

  task automatic run_to(input int e);
    while (nxt < e) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; locked_in = 1'b0; force_relock = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    nxt = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", nm, nxt - 1, act, exp);
    end else if (!quiet) begin
      $display("ok   %s edge=%0d value=%0h", nm, nxt - 1, act);
    end
  endtask

  typedef struct {
    int            e;
    logic          lk;
    logic          frc;
    logic          prb;
    logic [N-1:0]  ro;
    logic          rdy;
    logic [CW-1:0] lc;
    logic [CW-1:0] tc;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Power-up, 1-cycle loss in RUN, then force_relock from RUN.
    tbl.push_back(vec_t'{0,  1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 4'd0, 4'd0});
    tbl.push_back(vec_t'{3,  1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 4'd0, 4'd0});
    tbl.push_back(vec_t'{4,  1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 4'd0, 4'd0});
    tbl.push_back(vec_t'{10, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 4'd0, 4'd0});
    tbl.push_back(vec_t'{19, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 4'd0, 4'd0});
    tbl.push_back(vec_t'{20, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 4'd0, 4'd0});
    tbl.push_back(vec_t'{24, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 4'd0, 4'd0});
    tbl.push_back(vec_t'{25, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 4'd0, 4'd0});
    tbl.push_back(vec_t'{29, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 4'd0, 4'd0});
    tbl.push_back(vec_t'{30, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 4'd0, 4'd0});
    tbl.push_back(vec_t'{50, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 4'd0, 4'd0});
    tbl.push_back(vec_t'{51, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 4'd0, 4'd0});
    tbl.push_back(vec_t'{52, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 4'd1, 4'd0});
    tbl.push_back(vec_t'{55, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 4'd1, 4'd0});
    tbl.push_back(vec_t'{56, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 4'd1, 4'd0});
    tbl.push_back(vec_t'{64, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 4'd1, 4'd0});
    tbl.push_back(vec_t'{65, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 4'd1, 4'd0});
    tbl.push_back(vec_t'{75, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 4'd1, 4'd0});
    tbl.push_back(vec_t'{76, 1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 4'd1, 4'd0});
    tbl.push_back(vec_t'{79, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 4'd1, 4'd0});
    tbl.push_back(vec_t'{80, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 4'd1, 4'd0});
    tbl.push_back(vec_t'{99, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 4'd1, 4'd0});

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      run_to(tbl[i].e);
      locked_in = tbl[i].lk; force_relock = tbl[i].frc;
      tick();
      force_relock = 1'b0;
      chk($sformatf("vec%0d", i), dut_vec(),
          32'({tbl[i].prb, tbl[i].ro, tbl[i].rdy, tbl[i].lc, tbl[i].tc}));
    end

    // Reset while in RUN with a nonzero loss counter.
    reset = 1'b1;
    tick();
    chk("reset_in_run", dut_vec(), 32'({1'b0, 3'b111, 1'b0, 4'd0, 4'd0}));
    reset = 1'b0; nxt = 0;
    // force_relock inside PLL_RESET must not restart the RESETB timer.
    run_to(2);
    force_relock = 1'b1; tick(); force_relock = 1'b0;
    tick(); chk("frc_in_rst_e3", 32'(pll_resetb), 32'd0);
    tick(); chk("frc_in_rst_e4", 32'(pll_resetb), 32'd1);

    // Glitchy lock.
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      locked_in = ((e >= 10) && (e < 15)) || (e >= 20);
      tick();
      if (e == 20) chk("glitch_e20", 32'(rst_out), 32'd7);
      if (e == 29) chk("glitch_e29", 32'(rst_out), 32'd7);
      if (e == 30) chk("glitch_e30", dut_vec(), 32'({1'b1, 3'b110, 1'b0, 4'd0, 4'd0}));
    end

    // Loss mid-RELEASE together with force_relock.
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      locked_in = (e >= 10) && (e < 22);
      force_relock = (e == 24);
      tick();
      if (e == 23) chk("midrel_e23", 32'({pll_resetb, rst_out}), 32'({1'b1, 3'b110}));
      if (e == 24) chk("midrel_e24", dut_vec(), 32'({1'b0, 3'b111, 1'b0, 4'd1, 4'd0}));
      if (e == 27) chk("midrel_e27", 32'(pll_resetb), 32'd0);
      if (e == 28) chk("midrel_e28", 32'(pll_resetb), 32'd1);
      if (e == 30) chk("midrel_lc", 32'(loss_count), 32'd1);
    end
    force_relock = 1'b0;

    // Timeout with no lock: RESETB drops every PRC+TO edges, counter saturates.
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      run_to((PRC + TO) * k - 1);
      tick(); chk($sformatf("tmo%0d_pre", k), 32'(pll_resetb), 32'd1);
      tick(); chk($sformatf("tmo%0d", k), 32'({pll_resetb, timeout_count}),
                  32'({1'b0, CW'((k < SAT) ? k : SAT)}));
    end

    // Randomised lock traffic against the reference.
    do_reset();
    quiet = 1'b1;
    begin
      int seg;
      int bad0;
      seg = 0;
      bad0 = bad;
      for (int c = 0; c < 6000; c++) begin
        if (seg == 0) begin
          seg = int'($urandom_range(1, 150));
          locked_in = ($urandom_range(0, 3) != 0);
        end
        seg--;
        force_relock = ($urandom_range(0, 199) == 0);
        reset = ($urandom_range(0, 2499) == 0);
        tick();
        chk("rand", dut_vec(), model_vec());
      end
      $display("random phase: 6000 cycles, %0d discrepancies", bad - bad0);
    end
    reset = 1'b0; force_relock = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
